fib_seq_engine: RTL and testbench
=================================

Name: fib_seq_engine

Overview:
- Parametrised successor to the fixed-width Fibonacci generator; control and datapath in one block.
- Computes term F(n) of a generalised Fibonacci sequence: F(0)=seed_a, F(1)=seed_b, F(k)=F(k-1)+F(k-2).
- Supports Fibonacci (seeds 0,1), Lucas (seeds 2,1) and arbitrary seeds.
- Two modes: final-term-only, or streaming every term with valid/ready backpressure. Overflow is detected per term.

Parameters:
DATA_W, 32, width of seeds, terms and result
IDX_W, 6, width of term index n (max n = 2^IDX_W-1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
start  in  1  request pulse; sampled only in IDLE
abort  in  1  synchronous; returns to IDLE from any state next edge, no done
mode  in  1  0 = final term only, 1 = stream all terms F(0)..F(n)
n  in  IDX_W  index of last term; latched on accepted start
seed_a  in  DATA_W  F(0); latched on accepted start
seed_b  in  DATA_W  F(1); latched on accepted start
busy  out  1  high in every state except IDLE
out_valid  out  1  stream-mode term valid
out_ready  in  1  stream-mode consumer ready
out_data  out  DATA_W  stream-mode term value
out_idx  out  IDX_W  index of out_data
out_ovf  out  1  out_data term overflowed
result  out  DATA_W  F(n); held until next accepted start
overflow  out  1  F(n) overflowed; held with result
done  out  1  one-cycle pulse when result/overflow are updated

Behaviour:
- Reset values: state IDLE; all outputs 0; internal a, b, idx, ovf bits 0.
- States:
  - IDLE: start=1 latches n, mode and seeds; sets a=seed_a, b=seed_b, a_ovf=b_ovf=0, idx=0; goes to RUN.
  - RUN: one term per step. A step occurs every cycle in mode 0, and only on out_valid&&out_ready in mode 1.
    - Step with idx==n: result<=a, overflow<=a_ovf; go to DONE.
    - Step with idx!=n: a<=b, a_ovf<=b_ovf, b<=a+b, b_ovf<=carry|a_ovf|b_ovf, idx<=idx+1.
  - DONE: done=1 for exactly one cycle, busy=1; next edge goes to IDLE.
- Latency, mode 0: start sampled at edge S; done high in the cycle following edge S+n+1. n=0 gives done one cycle after the start edge with result=seed_a.
- Stream mode:
  - out_valid=1 throughout RUN; out_data=a, out_idx=idx, out_ovf=a_ovf.
  - Terms are presented in order 0..n, n+1 transfers total.
  - While out_ready=0, outputs are held stable and no step occurs.
  - The final transfer (idx==n) also triggers the DONE transition.
- Mode 0: out_valid stays 0; out_data, out_idx and out_ovf are don't-care but driven 0.
- Arithmetic: the sum is DATA_W+1 bits; carry = bit DATA_W. Without the optional feature, terms wrap mod 2^DATA_W. Overflow is sticky along the sequence: once a term overflows, all later terms are flagged.
- Term F(n+1) is never computed beyond the step it feeds. It never affects overflow of F(n).
- Start while busy is ignored and does not corrupt latched inputs.
- Start and abort in the same IDLE cycle: abort wins; the block stays IDLE.
- Abort: from RUN or DONE, the next edge enters IDLE. result/overflow keep their previous values and no done pulse occurs. Abort during a stalled stream drops out_valid on the next edge.
- Reset mid-operation: immediate return to IDLE with all outputs 0, including result.
- n=2^IDX_W-1: idx must not wrap before the compare; the final step occurs at idx==n.

Optional Feature:
- Macro FIB_SATURATE_EN.
- Defined: an overflowing sum clamps b to all-ones (2^DATA_W-1). A clamped a also makes its successors all-ones. Overflow flags behave identically.
- Undefined: modular wrap as above.

Decomposition:
- Package fib_pkg holds:
  - state enum: IDLE, RUN, DONE
  - mode constants: MODE_FINAL=0, MODE_STREAM=1
- One natural sub-module: fib_step_dp, the a/b/idx/ovf registers plus adder with saturate logic, driven by step/load enables from the FSM in fib_seq_engine.

Test Plan:
1. DATA_W=32, mode 0, seeds 0/1, n=10 -> done once, 11 cycles after start edge; result=55, overflow=0, busy low next cycle.
2. Mode 0, seeds 2/1 (Lucas), n=0 then n=1 -> results 2 then 1; done one cycle after start for n=0.
3. DATA_W=8, seeds 0/1, n=14 -> result=121 (377 mod 256), overflow=1. With FIB_SATURATE_EN: result=255, overflow=1. n=13 -> 233, overflow=0.
4. Mode 1, seeds 0/1, n=5, out_ready toggled 1,0,0,1,... -> exactly 6 transfers with data 0,1,1,2,3,5 and out_idx 0..5; data held stable while stalled; done after last transfer.
5. Mode 0, n=20; assert start again mid-run, then abort at cycle 7 -> second start ignored; IDLE next edge; no done; result keeps its prior value.
6. Reset low mid-run with n=30 -> all outputs 0 immediately; a fresh start with n=3 afterwards gives result=2.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and constants for the generalised Fibonacci sequence engine.
package fib_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_FINAL  = 1'b0;
   localparam logic MODE_STREAM = 1'b1;

endpackage

// File: rtl/fib_seq_engine_if.sv
// Control, stream and result bundle of fib_seq_engine; the engine is the slave side.
interface fib_seq_engine_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IDX_W  = 6
);
   logic              start;
   logic              abort;
   logic              mode;
   logic [IDX_W-1:0]  n;
   logic [DATA_W-1:0] seed_a;
   logic [DATA_W-1:0] seed_b;
   logic              busy;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [IDX_W-1:0]  out_idx;
   logic              out_ovf;
   logic [DATA_W-1:0] result;
   logic              overflow;
   logic              done;

   modport master (
      output start, abort, mode, n, seed_a, seed_b, out_ready,
      input  busy, out_valid, out_data, out_idx, out_ovf, result, overflow, done
   );

   modport slave (
      input  start, abort, mode, n, seed_a, seed_b, out_ready,
      output busy, out_valid, out_data, out_idx, out_ovf, result, overflow, done
   );
endinterface

// File: rtl/fib_step_dp.sv
// Term datapath: holds F(idx) in a and F(idx+1) in b with sticky overflow flags.
// FIB_SATURATE_EN clamps overflowed terms to all-ones instead of wrapping.
module fib_step_dp #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IDX_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              step,
   input  logic [IDX_W-1:0]  n,
   input  logic [DATA_W-1:0] seed_a,
   input  logic [DATA_W-1:0] seed_b,
   output logic [DATA_W-1:0] a,
   output logic              a_ovf,
   output logic [IDX_W-1:0]  idx,
   output logic              at_last_c
);

   logic [DATA_W-1:0] b_q;
   logic              b_ovf_q;
   logic [IDX_W-1:0]  n_q;
   logic [DATA_W:0]   sum_c;
   logic              ovf_next_c;
   logic [DATA_W-1:0] b_next_c;

   // Sum keeps the carry bit; once any term overflowed, every later one is flagged.
   always_comb begin
      sum_c      = {1'b0, a} + {1'b0, b_q};
      ovf_next_c = sum_c[DATA_W] | a_ovf | b_ovf_q;
`ifdef FIB_SATURATE_EN
      b_next_c   = ovf_next_c ? {DATA_W{1'b1}} : sum_c[DATA_W-1:0];
`else
      b_next_c   = sum_c[DATA_W-1:0];
`endif
   end

   // Compare before incrementing so idx never wraps at n = 2^IDX_W-1.
   assign at_last_c = (idx == n_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a       <= '0;
         a_ovf   <= 1'b0;
         b_q     <= '0;
         b_ovf_q <= 1'b0;
         idx     <= '0;
         n_q     <= '0;
      end else if (load) begin
         a       <= seed_a;
         a_ovf   <= 1'b0;
         b_q     <= seed_b;
         b_ovf_q <= 1'b0;
         idx     <= '0;
         n_q     <= n;
      end else if (step && !at_last_c) begin
         a       <= b_q;
         a_ovf   <= b_ovf_q;
         b_q     <= b_next_c;
         b_ovf_q <= ovf_next_c;
         idx     <= idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/fib_seq_engine.sv
// Generalised Fibonacci engine: final-term or streaming mode with valid/ready backpressure.
// Build option FIB_SATURATE_EN (in fib_step_dp) selects saturating instead of wrapping terms.
module fib_seq_engine
   import fib_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IDX_W  = 6
) (
   input  logic           clk,
   input  logic           reset,
   fib_seq_engine_if.slave bus
);

   state_t            state_q, state_d;
   logic              mode_q, mode_d;
   logic              busy_q, out_valid_q, done_q, overflow_q;
   logic [DATA_W-1:0] result_q;

   logic              load_c, step_c, fin_c, step_en_c, at_last_c;
   logic [DATA_W-1:0] a;
   logic              a_ovf;
   logic [IDX_W-1:0]  idx;

   fib_step_dp #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_dp (
      .clk       (clk),
      .reset     (reset),
      .load      (load_c),
      .step      (step_c),
      .n         (bus.n),
      .seed_a    (bus.seed_a),
      .seed_b    (bus.seed_b),
      .a         (a),
      .a_ovf     (a_ovf),
      .idx       (idx),
      .at_last_c (at_last_c)
   );

   // Next state and step control; abort has priority over start and stepping.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      load_c    = 1'b0;
      step_c    = 1'b0;
      fin_c     = 1'b0;
      step_en_c = (mode_q == MODE_FINAL) || (out_valid_q && bus.out_ready);
      case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_d = RUN;
               mode_d  = bus.mode;
               load_c  = 1'b1;
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (step_en_c) begin
               if (at_last_c) begin
                  fin_c   = 1'b1;
                  state_d = DONE;
               end else begin
                  step_c  = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         mode_q      <= MODE_FINAL;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         busy_q      <= (state_d != IDLE);
         out_valid_q <= (state_d == RUN) && (mode_d == MODE_STREAM);
         done_q      <= fin_c;
         if (fin_c) begin
            result_q   <= a;
            overflow_q <= a_ovf;
         end
      end
   end

   // Stream outputs show the current term only while offered; otherwise driven 0.
   assign bus.busy      = busy_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_valid_q ? a : '0;
   assign bus.out_idx   = out_valid_q ? idx : '0;
   assign bus.out_ovf   = out_valid_q & a_ovf;
   assign bus.result    = result_q;
   assign bus.overflow  = overflow_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_fib_seq_engine.sv
// Self-checking bench: 32-bit and 8-bit engines run the same jobs against a term-by-term reference.
module tb_fib_seq_engine;
   import fib_pkg::*;

`ifdef FIB_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fib_seq_engine_if #(.DATA_W(32), .IDX_W(6)) bus32 ();
   fib_seq_engine_if #(.DATA_W(8),  .IDX_W(6)) bus8 ();

   fib_seq_engine #(.DATA_W(32), .IDX_W(6)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32));
   fib_seq_engine #(.DATA_W(8),  .IDX_W(6)) u_dut8  (.clk(clk), .reset(reset), .bus(bus8));

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [31:0] exp_res32 = '0, exp_res8 = '0;
   logic        exp_ovf32 = 1'b0, exp_ovf8 = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: F(k) for width w from the recurrence, with sticky overflow; returns {ovf, value}.
   function automatic logic [64:0] ref_term(input int unsigned w, input logic [31:0] sa,
                                            input logic [31:0] sb, input int unsigned k);
      longint unsigned mx, p, q, s;
      bit po, qo, so;
      mx = (64'd1 << w) - 64'd1;
      p = 64'(sa) & mx;
      q = 64'(sb) & mx;
      po = 1'b0;
      qo = 1'b0;
      if (k == 0) return {1'b0, p};
      for (int unsigned i = 2; i <= k; i++) begin
         s  = p + q;
         so = (s > mx) || po || qo;
         if (SAT && so) s = mx;
         else           s = s & mx;
         p = q; po = qo;
         q = s; qo = so;
      end
      return {qo, q};
   endfunction

   task automatic drive(input bit st, input bit ab, input bit md, input int unsigned nn,
                        input logic [31:0] sa, input logic [31:0] sb);
      bus32.start = st;  bus8.start = st;
      bus32.abort = ab;  bus8.abort = ab;
      bus32.mode  = md;  bus8.mode  = md;
      bus32.n = 6'(nn);  bus8.n = 6'(nn);
      bus32.seed_a = sa; bus8.seed_a = sa[7:0];
      bus32.seed_b = sb; bus8.seed_b = sb[7:0];
   endtask

   task automatic set_ready(input bit r);
      bus32.out_ready = r;
      bus8.out_ready  = r;
   endtask

   // One complete job; pat selects ready pattern 1,0,0,..., mid re-asserts start mid-run.
   task automatic run_job(input bit md, input int unsigned nn, input logic [31:0] sa,
                          input logic [31:0] sb, input bit pat, input bit mid);
      logic [64:0] r32, r8;
      logic [31:0] held;
      int unsigned cyc, xfer, k_rdy, budget;
      bit stalled, last_xfer, seen, rdy;
      cyc = 0; xfer = 0; k_rdy = 0; stalled = 0; last_xfer = 0; seen = 0;
      budget = 4 * (nn + 2) + 10;
      @(negedge clk);
      drive(1'b1, 1'b0, md, nn, sa, sb);
      @(negedge clk);
      drive(1'b0, 1'b0, ~md, $urandom_range(0, 63), $urandom, $urandom);
      check("busy_after_start", 64'(bus32.busy), 64'd1);
      while (cyc <= budget) begin
         if (bus32.done) begin
            seen = 1'b1;
            break;
         end
         if (md == MODE_FINAL && cyc == 0) begin
            check("final_out_valid", 64'(bus32.out_valid), 64'd0);
            check("final_out_data", 64'(bus32.out_data), 64'd0);
         end
         if (md == MODE_STREAM) begin
            if (stalled) begin
               check("stall_hold_data", 64'(bus32.out_data), 64'(held));
               check("stall_hold_valid", 64'(bus32.out_valid), 64'd1);
            end
            rdy = pat ? ((k_rdy % 3) == 0) : ($urandom_range(0, 3) != 0);
            k_rdy++;
            set_ready(rdy);
            last_xfer = 1'b0;
            stalled = 1'b0;
            if (bus32.out_valid) begin
               if (rdy) begin
                  r32 = ref_term(32, sa, sb, xfer);
                  r8  = ref_term(8, sa, sb, xfer);
                  check("s32_data", 64'(bus32.out_data), r32[63:0]);
                  check("s32_ovf",  64'(bus32.out_ovf), 64'(r32[64]));
                  check("s32_idx",  64'(bus32.out_idx), 64'(xfer));
                  check("s8_data",  64'(bus8.out_data), r8[63:0]);
                  check("s8_ovf",   64'(bus8.out_ovf), 64'(r8[64]));
                  xfer++;
                  last_xfer = 1'b1;
               end else begin
                  stalled = 1'b1;
                  held = bus32.out_data;
               end
            end
         end
         if (mid && cyc == 2) drive(1'b1, 1'b0, ~md, 63, 32'd77, 32'd99);
         if (mid && cyc == 3) drive(1'b0, 1'b0, md, nn, sa, sb);
         @(negedge clk);
         cyc++;
      end
      set_ready(1'b0);
      if (!seen) begin
         check("done_timeout", 64'd0, 64'd1);
         return;
      end
      if (md == MODE_FINAL) check("latency", 64'(cyc), 64'(nn + 1));
      else begin
         check("xfer_count", 64'(xfer), 64'(nn + 1));
         check("done_after_last", 64'(last_xfer), 64'd1);
      end
      r32 = ref_term(32, sa, sb, nn);
      r8  = ref_term(8, sa, sb, nn);
      check("result32", 64'(bus32.result), r32[63:0]);
      check("overflow32", 64'(bus32.overflow), 64'(r32[64]));
      check("result8", 64'(bus8.result), r8[63:0]);
      check("overflow8", 64'(bus8.overflow), 64'(r8[64]));
      exp_res32 = r32[31:0]; exp_ovf32 = r32[64];
      exp_res8  = r8[31:0];  exp_ovf8  = r8[64];
      @(negedge clk);
      check("done_one_cycle", 64'(bus32.done), 64'd0);
      check("idle_after_done", 64'(bus32.busy), 64'd0);
   endtask

   task automatic check_held_result(input string tag);
      check({tag, "_res32"}, 64'(bus32.result), 64'(exp_res32));
      check({tag, "_ovf32"}, 64'(bus32.overflow), 64'(exp_ovf32));
      check({tag, "_res8"},  64'(bus8.result), 64'(exp_res8));
   endtask

   initial begin
      int unsigned dcnt;
      int unsigned rn;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 0, 32'd0, 32'd0);
      set_ready(1'b0);
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(bus32.busy), 64'd0);
      check("rst_valid", 64'(bus32.out_valid), 64'd0);
      check("rst_done", 64'(bus32.done), 64'd0);
      check("rst_result", 64'(bus32.result), 64'd0);
      check("rst_overflow", 64'(bus32.overflow), 64'd0);
      check("rst_out_data", 64'(bus32.out_data), 64'd0);
      reset = 1'b1;

      // Directed: Fibonacci, Lucas, 8-bit overflow boundary, streaming pattern.
      run_job(MODE_FINAL, 10, 32'd0, 32'd1, 1'b0, 1'b0);
      run_job(MODE_FINAL, 0, 32'd2, 32'd1, 1'b0, 1'b0);
      run_job(MODE_FINAL, 1, 32'd2, 32'd1, 1'b0, 1'b0);
      run_job(MODE_FINAL, 14, 32'd0, 32'd1, 1'b0, 1'b0);
      run_job(MODE_FINAL, 13, 32'd0, 32'd1, 1'b0, 1'b0);
      run_job(MODE_STREAM, 5, 32'd0, 32'd1, 1'b1, 1'b0);
      run_job(MODE_FINAL, 8, 32'd0, 32'd1, 1'b0, 1'b1);
      run_job(MODE_FINAL, 63, 32'd0, 32'd1, 1'b0, 1'b0);
      run_job(MODE_STREAM, 63, 32'd2, 32'd1, 1'b0, 1'b0);

      // Abort mid-run after an ignored second start.
      @(negedge clk);
      drive(1'b1, 1'b0, MODE_FINAL, 20, 32'd0, 32'd1);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         drive(c == 2, c == 6, MODE_FINAL, 3, 32'd5, 32'd5);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, MODE_FINAL, 0, 32'd0, 32'd0);
      check("abort_busy", 64'(bus32.busy), 64'd0);
      check("abort_done", 64'(bus32.done), 64'd0);
      check_held_result("abort_keep");
      dcnt = 0;
      repeat (25) begin
         @(negedge clk);
         if (bus32.done || bus8.done) dcnt++;
      end
      check("abort_no_done", 64'(dcnt), 64'd0);

      // Start and abort together in IDLE: abort wins.
      drive(1'b1, 1'b1, MODE_FINAL, 2, 32'd1, 32'd1);
      @(negedge clk);
      drive(1'b0, 1'b0, MODE_FINAL, 0, 32'd0, 32'd0);
      check("start_abort_idle", 64'(bus32.busy), 64'd0);

      // Abort during a stalled stream.
      set_ready(1'b0);
      drive(1'b1, 1'b0, MODE_STREAM, 10, 32'd7, 32'd9);
      @(negedge clk);
      drive(1'b0, 1'b0, MODE_STREAM, 10, 32'd7, 32'd9);
      repeat (2) @(negedge clk);
      check("stall_valid", 64'(bus32.out_valid), 64'd1);
      check("stall_data", 64'(bus32.out_data), 64'd7);
      drive(1'b0, 1'b1, MODE_STREAM, 10, 32'd7, 32'd9);
      @(negedge clk);
      drive(1'b0, 1'b0, MODE_FINAL, 0, 32'd0, 32'd0);
      check("stall_abort_valid", 64'(bus32.out_valid), 64'd0);
      check("stall_abort_busy", 64'(bus32.busy), 64'd0);
      check_held_result("stall_abort_keep");

      // Randomised jobs.
      for (int j = 0; j < 20; j++) begin
         rn = $urandom_range(0, 63);
         case ($urandom_range(0, 2))
            0:       run_job(1'($urandom), rn, 32'd0, 32'd1, 1'b0, 1'b0);
            1:       run_job(1'($urandom), rn, 32'd2, 32'd1, 1'b0, 1'b0);
            default: run_job(1'($urandom), rn, $urandom, $urandom, 1'b0, 1'b0);
         endcase
      end

      // Reset mid-run, then a fresh job.
      run_job(MODE_FINAL, 10, 32'd0, 32'd1, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 1'b0, MODE_FINAL, 30, 32'd0, 32'd1);
      @(negedge clk);
      drive(1'b0, 1'b0, MODE_FINAL, 0, 32'd0, 32'd0);
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_busy", 64'(bus32.busy), 64'd0);
      check("midrst_result", 64'(bus32.result), 64'd0);
      check("midrst_result8", 64'(bus8.result), 64'd0);
      check("midrst_done", 64'(bus32.done), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      run_job(MODE_FINAL, 3, 32'd0, 32'd1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1);
   end

endmodule
